// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver with 16x oversampling and 3-sample majority
// voting. It is the receive-side partner of the uart_top transmitter and uses
// the same Baudrate_Set encoding.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   Baudrate_Set 0=9600 1=19200 2=38400 3=57600 4=115200 5..7=9600
//   data_rx      asynchronous serial input, idles high
//   data         last correctly framed byte
//   Rx_Done      one-cycle strobe; data is valid from this cycle on
//   frame_err    one-cycle strobe when the stop bit samples low
//   busy         high while a frame is in progress
module uart_byte_rx #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] Baudrate_Set,
  input  logic       data_rx,
  output logic [7:0] data,
  output logic       Rx_Done,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV_9600   = CLK_FREQ / (9600   * 16);
  localparam int DIV_19200  = CLK_FREQ / (19200  * 16);
  localparam int DIV_38400  = CLK_FREQ / (38400  * 16);
  localparam int DIV_57600  = CLK_FREQ / (57600  * 16);
  localparam int DIV_115200 = CLK_FREQ / (115200 * 16);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_n;
  logic        sync1, sync2, edge_q;
  logic [2:0]  baud_q;
  logic [15:0] div_cnt, div_last;
  logic [3:0]  tick_idx;
  logic [2:0]  bit_cnt;
  logic [1:0]  smp;
  logic [7:0]  shift_reg;
  logic        tick, fall, maj, at9, at15;
  logic        start_det, shift_en, bit_inc, done_set, ferr_set;

  // Divisor comes from the baud latched at start so a mid-frame change of
  // Baudrate_Set cannot disturb the frame being received.
  always_comb begin
    case (baud_q)
      3'd1:    div_last = 16'(DIV_19200  - 1);
      3'd2:    div_last = 16'(DIV_38400  - 1);
      3'd3:    div_last = 16'(DIV_57600  - 1);
      3'd4:    div_last = 16'(DIV_115200 - 1);
      default: div_last = 16'(DIV_9600   - 1);
    endcase
  end

  assign tick = (div_cnt == div_last);
  assign fall = edge_q & ~sync2;
  // Samples from ticks 7 and 8 are held in smp; tick 9 uses the live value.
  assign maj  = (smp[0] & smp[1]) | (smp[0] & sync2) | (smp[1] & sync2);
  assign at9  = tick && (tick_idx == 4'd9);
  assign at15 = tick && (tick_idx == 4'd15);
  assign busy = (state != IDLE);

  always_comb begin
    state_n   = state;
    start_det = 1'b0;
    shift_en  = 1'b0;
    bit_inc   = 1'b0;
    done_set  = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE: if (fall) begin
        state_n   = START;
        start_det = 1'b1;
      end
      START: begin
        if (at9 && maj)  state_n = IDLE;   // glitch, not a real start bit
        else if (at15)   state_n = DATA;
      end
      DATA: begin
        if (at9) shift_en = 1'b1;
        if (at15) begin
          if (bit_cnt == 3'd7) state_n = STOP;
          else                 bit_inc = 1'b1;
        end
      end
      STOP: if (at9) begin
        // Leave at mid-stop so a following start edge is never missed.
        state_n = IDLE;
        if (maj) done_set = 1'b1;
        else     ferr_set = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      edge_q    <= 1'b1;
      state     <= IDLE;
      baud_q    <= 3'd0;
      div_cnt   <= 16'd0;
      tick_idx  <= 4'd0;
      bit_cnt   <= 3'd0;
      smp       <= 2'b11;
      shift_reg <= 8'h00;
      data      <= 8'h00;
      Rx_Done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync1     <= data_rx;
      sync2     <= sync1;
      edge_q    <= sync2;
      state     <= state_n;
      Rx_Done   <= done_set;
      frame_err <= ferr_set;

      if (start_det) begin
        baud_q   <= Baudrate_Set;
        div_cnt  <= 16'd0;
        tick_idx <= 4'd0;
        bit_cnt  <= 3'd0;
      end else if (state == IDLE) begin
        div_cnt  <= 16'd0;
      end else if (tick) begin
        div_cnt  <= 16'd0;
        tick_idx <= tick_idx + 4'd1;   // wraps 15 -> 0 at each bit boundary
        if (tick_idx == 4'd7) smp[0] <= sync2;
        if (tick_idx == 4'd8) smp[1] <= sync2;
      end else begin
        div_cnt  <= div_cnt + 16'd1;
      end

      if (shift_en) shift_reg[bit_cnt] <= maj;
      if (bit_inc)  bit_cnt <= bit_cnt + 3'd1;
      if (done_set) data <= shift_reg;
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx. Runs the receiver at CLK_FREQ = 10 MHz so the
// 9600-baud back-to-back frames fit a short run; divisors are
// floor(10e6/(baud*16)): 9600 -> 65, 115200 -> 5. Expected strobes are queued
// by the stimulus and consumed by a separate monitor.
module tb_uart_byte_rx;
  localparam int CLK_FREQ  = 10_000_000;
  localparam int DIV_115K  = 5;
  localparam int DIV_9600  = 65;
  localparam int BIT_115K  = 16 * DIV_115K;   // 80 clk per bit
  localparam int BIT_9600  = 16 * DIV_9600;   // 1040 clk per bit
  localparam int LAT_MIN   = 9*16*DIV_115K + 10*DIV_115K;   // 770
  localparam int SPK_AT    = 44;  // spike covers only the tick-8 sample

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] Baudrate_Set = 3'd4;
  logic       data_rx = 1'b1;
  logic [7:0] data;
  logic       Rx_Done, frame_err, busy;

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk(clk), .rst(rst), .Baudrate_Set(Baudrate_Set), .data_rx(data_rx),
    .data(data), .Rx_Done(Rx_Done), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   checks = 0, passed = 0;
  int   cyc = 0, done_cyc = 0, t_start = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok, input int act, input int exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  always @(posedge clk) begin
    #1;
    if (Rx_Done || frame_err) begin
      if (Rx_Done) done_cyc = cyc;
      chk("strobe_excl", !(Rx_Done && frame_err), {Rx_Done, frame_err}, 2);
      chk("unexpected_strobe", sb.size() != 0, {Rx_Done, frame_err}, 0);
      if (sb.size() != 0) begin
        m_e = sb.pop_front();
        chk("strobe_kind_ferr", frame_err == m_e.ferr, frame_err, m_e.ferr);
        chk("strobe_data", data == m_e.data, int'(data), int'(m_e.data));
      end
    end
  end

  // One 8N1 frame, driven on negedges. spike inverts data bits around the
  // tick-8 sample; chg >= 0 moves Baudrate_Set to 0 at that frame bit.
  task automatic send(input logic [7:0] b, input int bitc, input bit stop_v,
                      input bit spike, input int chg);
    logic [9:0] fr;
    fr = {stop_v, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (i == chg) Baudrate_Set = 3'd0;
      if (i == 0) t_start = cyc;
      data_rx = fr[i];
      if (spike && i >= 1 && i <= 8) begin
        repeat (SPK_AT) @(negedge clk);
        data_rx = ~fr[i];
        repeat (3) @(negedge clk);
        data_rx = fr[i];
        repeat (bitc - SPK_AT - 3) @(negedge clk);
      end else begin
        repeat (bitc) @(negedge clk);
      end
    end
  endtask

  task automatic expect_byte(input logic ferr, input logic [7:0] d);
    exp_t e;
    e.ferr = ferr;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 4000 && sb.size() != 0; i++) @(negedge clk);
    chk({"drain_", name}, sb.size() == 0, sb.size(), 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: time limit reached, %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] fr;
    int lat;
    repeat (3) @(negedge clk);
    chk("rst_data",      data == 8'h00, int'(data), 0);
    chk("rst_rx_done",   Rx_Done == 1'b0, Rx_Done, 0);
    chk("rst_frame_err", frame_err == 1'b0, frame_err, 0);
    chk("rst_busy",      busy == 1'b0, busy, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 115200, 0x55, latency window
    done_cyc = 0;
    expect_byte(1'b0, 8'h55);
    send(8'h55, BIT_115K, 1'b1, 1'b0, -1);
    lat = done_cyc - t_start;
    chk("latency", lat >= LAT_MIN && lat <= LAT_MIN + 3, lat, LAT_MIN);
    chk("busy_after_55", busy == 1'b0, busy, 0);
    drain("t1");

    // 9600 back-to-back
    Baudrate_Set = 3'd0;
    expect_byte(1'b0, 8'h00);
    expect_byte(1'b0, 8'hFF);
    expect_byte(1'b0, 8'hA3);
    send(8'h00, BIT_9600, 1'b1, 1'b0, -1);
    send(8'hFF, BIT_9600, 1'b1, 1'b0, -1);
    send(8'hA3, BIT_9600, 1'b1, 1'b0, -1);
    Baudrate_Set = 3'd4;
    drain("t2");

    // Frame error, data holds 0xA3; line high 1 bit then 0x81
    expect_byte(1'b1, 8'hA3);
    send(8'h3C, BIT_115K, 1'b0, 1'b0, -1);
    data_rx = 1'b1;
    repeat (BIT_115K) @(negedge clk);
    expect_byte(1'b0, 8'h81);
    send(8'h81, BIT_115K, 1'b1, 1'b0, -1);
    drain("t3");
    chk("data_81", data == 8'h81, int'(data), 8'h81);

    // Short low glitch on the idle line
    data_rx = 1'b0;
    repeat (18) @(negedge clk);
    data_rx = 1'b1;
    repeat (BIT_115K - 18) @(negedge clk);
    chk("glitch_busy", busy == 1'b0, busy, 0);
    repeat (4 * BIT_115K) @(negedge clk);
    drain("t4");

    // Spikes on the middle sample are outvoted
    expect_byte(1'b0, 8'h96);
    send(8'h96, BIT_115K, 1'b1, 1'b1, -1);
    drain("t5");

    // Reset during data bit 4 of 0x5A
    fr = {1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 5; i++) begin
      data_rx = fr[i];
      repeat (BIT_115K) @(negedge clk);
    end
    data_rx = fr[5];
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", busy == 1'b0, busy, 0);
    chk("rst_mid_data", data == 8'h00, int'(data), 0);
    data_rx = 1'b1;
    repeat (10 * BIT_115K) @(negedge clk);
    chk("rst_mid_idle", busy == 1'b0, busy, 0);
    expect_byte(1'b0, 8'h5A);
    send(8'h5A, BIT_115K, 1'b1, 1'b0, -1);
    drain("t6");

    // Baud select changed mid-frame is ignored
    expect_byte(1'b0, 8'hC7);
    send(8'hC7, BIT_115K, 1'b1, 1'b0, 3);
    Baudrate_Set = 3'd4;
    repeat (2 * BIT_115K) @(negedge clk);
    drain("t7");
    chk("data_c7", data == 8'hC7, int'(data), 8'hC7);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- UART receiver; the receive-direction counterpart to the team's `uart_top` transmitter.
- Decodes 8N1 frames (1 start, 8 data LSB-first, 1 stop, no parity) from an asynchronous serial pin.
- Uses the same 3-bit `Baudrate_Set` encoding as the transmitter, 16x oversampling, and 3-sample majority voting.
- Delivers each byte with a one-cycle `Rx_Done` strobe, so it can be looped back against the transmitter on the board.

Parameters:
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz; used to derive the oversample divisors.

Ports:
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `Baudrate_Set` in 3: baud select. 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5..7=9600.
- `data_rx` in 1: asynchronous serial input; idles high.
- `data` out 8: last correctly framed byte.
- `Rx_Done` out 1: one-cycle pulse; `data` is valid from this cycle onward.
- `frame_err` out 1: one-cycle pulse when the stop bit samples low.
- `busy` out 1: high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (`rst`=1 at a clk edge):
  - state=IDLE; `data`=0x00; `Rx_Done`=0; `frame_err`=0; `busy`=0.
  - Synchroniser flops and the edge-detect register are preset to 1.
  - Reset mid-frame abandons the frame; no strobes are produced.
- Synchroniser: `data_rx` passes through 2 flops, then a 3rd register for falling-edge detection. All sampling uses the synchronised signal.
- Oversample tick:
  - DIV = floor(CLK_FREQ/(baud*16)). At 50 MHz: 325, 162, 81, 54, 27.
  - Divider counter runs 0..DIV-1; a tick fires when it reaches DIV-1.
  - The counter is cleared on start detection.
  - `Baudrate_Set` is latched at start detection; changes mid-frame are ignored.
- Each bit period = 16 ticks, indexed 0..15.
  - Samples are taken at ticks 7, 8 and 9; the bit value is the majority (2 of 3), resolved at tick 9.
- FSM:
  - IDLE: on a synced falling edge -> START; clear tick index, divider and bit count; latch baud.
  - START: at tick 9, majority=0 -> continue. Majority=1 -> glitch: return to IDLE with no strobe. At tick 15 -> DATA.
  - DATA: at tick 9, shift the majority into `shift_reg[bit_cnt]` (LSB first). At tick 15: bit_cnt==7 -> STOP, else bit_cnt+1.
  - STOP: at tick 9, majority=1 -> `data`<=shift_reg, `Rx_Done`=1 for one cycle. Majority=0 -> `frame_err`=1 for one cycle and `data` is unchanged. Either way -> IDLE at the same cycle.
  - STOP returns to IDLE at tick 9, not tick 15, so that back-to-back frames and slight sender-fast skew are accepted.
- Strobe exclusivity: `Rx_Done` and `frame_err` are never high together.
- Line held low after a frame error: no new start is detected until `data_rx` returns high and falls again.
- Latency: pin falling edge to `Rx_Done` = 9*16*DIV + 10*DIV clk, +3/-0 clk (synchroniser, edge detect, registered output). At 115200 this is 4158 clk.
- Estimated RTL size: about 150-220 lines.

Test Plan:
- 115200 (set=4), frame 0x55 at 432 clk/bit -> single `Rx_Done` pulse 4158..4161 clk after the start edge; `data`=0x55; `frame_err`=0; `busy` low afterwards.
- 9600 (set=0), frames 0x00, 0xFF, 0xA3 back-to-back with no idle gap (5200 clk/bit) -> three `Rx_Done` pulses, `data`=0x00, then 0xFF, then 0xA3.
- 115200, 0x3C with the stop bit driven low -> one `frame_err` pulse, no `Rx_Done`, `data` holds its previous value. Line then high for 1 bit, then 0x81 sent -> `Rx_Done`, `data`=0x81.
- 115200, 100-clk low glitch on the idle line -> no `Rx_Done`, no `frame_err`, `busy` returns to 0 within 432 clk.
- 115200, 0x96 with a 20-clk inverted spike centred on sample tick 8 of each data bit -> majority rejects the spikes; `data`=0x96.
- `rst` asserted for 1 clk at data bit 4 of 0x5A, then a clean 0x5A sent -> no strobe for the aborted frame; `busy`=0 immediately after reset; the next frame yields `data`=0x5A. Also set `Baudrate_Set` to 0 mid-frame at 115200 -> the current frame still decodes correctly.
